// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared link parameters and types for the TX and RX paths
package link_pkg;

    localparam int BANDWIDTH = 1;
    localparam int WORD_SIZE = 2;
    localparam int BUFFER_IN = 2;
    localparam int BEATS     = WORD_SIZE / BANDWIDTH;

    typedef enum logic {
        RX_IDLE,
        RX_DATA
    } rx_state_t;

    typedef logic [WORD_SIZE-1:0] word_t;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - circular word queue with explicit level and sticky overflow
module word_fifo #(
    parameter int WORD_SIZE = link_pkg::WORD_SIZE,
    parameter int BUFFER_IN = link_pkg::BUFFER_IN,
    localparam int LEVEL_W  = $clog2(BUFFER_IN + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] head,
    output logic                 not_empty,
    output logic                 overflow,
    output logic [LEVEL_W-1:0]   level
);
    import link_pkg::*;

    localparam int PTR_W = (BUFFER_IN > 1) ? $clog2(BUFFER_IN) : 1;
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(BUFFER_IN - 1);
    localparam logic [LEVEL_W-1:0] FULL     = LEVEL_W'(BUFFER_IN);

    logic [WORD_SIZE-1:0] mem [BUFFER_IN];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic                 do_pop;
    logic                 do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop in the same cycle frees the slot a push into a full queue needs.
    always_comb begin
        do_pop  = pop && (level != '0);
        do_push = push && ((level != FULL) || do_pop);
    end

    assign head      = mem[rd_ptr];
    assign not_empty = (level != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BUFFER_IN; i++) begin
                mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + LEVEL_W'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LEVEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/rx_deserializer.sv
// rtl/rx_deserializer.sv - start-beat framed serial receiver feeding a word queue
module rx_deserializer #(
    parameter int BANDWIDTH = link_pkg::BANDWIDTH,
    parameter int WORD_SIZE = link_pkg::WORD_SIZE,
    parameter int BUFFER_IN = link_pkg::BUFFER_IN,
    localparam int LEVEL_W  = $clog2(BUFFER_IN + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BANDWIDTH-1:0] rx,
    input  logic                 adv_recv,
    output logic [WORD_SIZE-1:0] recv,
    output logic                 recv_buff_ready,
    output logic                 overflow,
    output logic [LEVEL_W-1:0]   level
);
    import link_pkg::*;

    localparam int FRAME_BEATS = WORD_SIZE / BANDWIDTH;
    localparam int CNT_W       = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    if (WORD_SIZE % BANDWIDTH != 0) begin : g_bad_width
        $error("WORD_SIZE must be a multiple of BANDWIDTH");
    end
    if (BUFFER_IN < 1) begin : g_bad_depth
        $error("BUFFER_IN must be at least 1");
    end

    rx_state_t            state;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 last_beat;
    logic [WORD_SIZE-1:0] word;

    assign last_beat = (state == RX_DATA) && (beat_cnt == CNT_W'(FRAME_BEATS - 1));

    // Earlier beats sit in the shift register; the current beat completes the word.
    if (FRAME_BEATS > 1) begin : g_shift
        localparam int SHIFT_W = WORD_SIZE - BANDWIDTH;
        logic [SHIFT_W-1:0] shift;

        assign word = {shift, rx};

        always_ff @(posedge clock) begin
            if (reset) begin
                shift <= '0;
            end else if (state == RX_DATA) begin
                shift <= word[SHIFT_W-1:0];
            end
        end
    end else begin : g_no_shift
        assign word = rx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RX_IDLE;
            beat_cnt <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (rx[0]) begin
                        state    <= RX_DATA;
                        beat_cnt <= '0;
                    end
                end
                RX_DATA: begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    if (last_beat) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    word_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .BUFFER_IN (BUFFER_IN)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (last_beat),
        .push_data (word),
        .pop       (adv_recv),
        .head      (recv),
        .not_empty (recv_buff_ready),
        .overflow  (overflow),
        .level     (level)
    );

endmodule

// File: doc/rx_deserializer.md
Name: rx_deserializer

Overview:
- Receive-side companion to the transceiver's TX path. It samples the BANDWIDTH-bit serial lane and detects a start beat.
- It assembles WORD_SIZE-bit words, MSB-first, and queues them in a BUFFER_IN-deep word FIFO.
- The consumer pops words with an adv_recv / recv_buff_ready handshake.
- Sits directly downstream of the link: its rx connects to a transceiver tx.

Parameters:
- BANDWIDTH, 1, serial lane width in bits per clock. WORD_SIZE must be a multiple of BANDWIDTH (elaboration error otherwise).
- WORD_SIZE, 2, bits per received word.
- BUFFER_IN, 2, FIFO depth in words. Must be ≥1. Need not be a power of two.

Ports:
- clock, input, 1, single system clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high.
- rx, input, BANDWIDTH, serial lane. Idle value is all-zero.
- adv_recv, input, 1, pop request for the head word.
- recv, output, WORD_SIZE, head-of-FIFO word. Valid while recv_buff_ready=1.
- recv_buff_ready, output, 1, FIFO non-empty.
- overflow, output, 1, sticky flag: a completed word was dropped because the FIFO was full.
- level, output, $clog2(BUFFER_IN+1), current FIFO occupancy in words.

Behaviour:
- Constants: BEATS = WORD_SIZE/BANDWIDTH.
- Frame format: one start beat with rx[0]=1, followed by exactly BEATS data beats.
  - The first data beat carries word bits [WORD_SIZE-1 -: BANDWIDTH]; later beats carry successively lower slices.
  - Other rx bits in the start beat are ignored.
- FSM has two states.
  - IDLE: if rx[0]=1, go to DATA with beat_cnt=0. Otherwise stay in IDLE.
  - DATA: each cycle, shift = {shift, rx} and increment beat_cnt. On the beat where beat_cnt = BEATS-1:
    - issue a push of {shift, rx};
    - go to IDLE.
  - Back-to-back frames are legal: a start beat in the cycle immediately after the last data beat is accepted.
- Receive latency: the word is visible on recv with recv_buff_ready=1 in the cycle after its last data beat, provided the FIFO was empty.
- FIFO: circular storage with rd_ptr/wr_ptr.
  - Pointers wrap from BUFFER_IN-1 to 0.
  - level is an explicit counter.
  - recv = mem[rd_ptr] (combinational read of registered storage).
  - recv_buff_ready = (level != 0).
- Pop: occurs when adv_recv=1 and level≠0. rd_ptr advances; the new head appears on recv the next cycle. adv_recv while empty is ignored, with no state change.
- Push when level < BUFFER_IN: write mem[wr_ptr], advance wr_ptr.
- Push when full with no pop in the same cycle: the word is dropped, overflow is set to 1, and pointers and level are unchanged.
- Push and pop in the same cycle:
  - both are performed and level is unchanged;
  - when full, the pop frees the slot, so no overflow occurs;
  - when empty, the pop is ignored and the push succeeds (level 0→1).
- overflow stays at 1 until reset.
- Reset (synchronous, may arrive mid-frame): the partial word is discarded, and the following are cleared:
  - state=IDLE, beat_cnt=0, shift=0;
  - pointers=0, level=0, mem cleared to 0;
  - outputs: recv=0, recv_buff_ready=0, overflow=0, level=0.
  - The rx value in the reset cycle is not interpreted as a start beat.
- Width rules:
  - beat_cnt width is $clog2(BEATS) (minimum 1 bit).
  - Pointer compares use BUFFER_IN-1, not power-of-two masking.
  - level never exceeds BUFFER_IN.

Decomposition:
- Shared package link_pkg holds:
  - BANDWIDTH, WORD_SIZE, BUFFER_IN, BEATS;
  - the enum rx_state_t {RX_IDLE, RX_DATA};
  - the word_t typedef logic[WORD_SIZE-1:0].
- The TX side should import the same package.
- One sub-module, word_fifo, holds the storage, pointers, level and overflow logic (push/pop/full/empty). rx_deserializer contains the FSM and shift register.

Test Plan:
- Defaults (BW=1, WS=2): rx 1,1,0 on cycles 0–2 → cycle 3: recv=2'b10, recv_buff_ready=1, level=1. adv_recv=1 on cycle 3 → cycle 4: recv_buff_ready=0, level=0.
- BW=2, WS=4: rx 01,11,00 → recv=4'b1100. Then back-to-back rx 01,10,01 immediately after → level=2, the second word 4'b1001 appears after popping the first.
- Defaults, no pops, three frames (10, 01, 11) → level=2, overflow=1, popped order 10 then 01; 11 is lost.
- FIFO full, and the last data beat of a frame coincides with adv_recv=1 → level stays 2, overflow=0, and the new word is read out after the remaining head.
- reset=1 in the cycle after a start beat → all outputs 0. A subsequent clean frame 1,0,1 → recv=2'b01, with no residue from the aborted frame.
- adv_recv=1 while empty, with rx held at 0 for 10 cycles → recv_buff_ready=0, level=0, overflow=0 throughout.
